sb_tx_packet_framer: RTL

//  Sideband transmit framer; the send-side counterpart of the sideband RX decode path.

---
 rtl/sb_tx_packet_framer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sb_tx_packet_framer.sv
// Sideband transmit framer: turns one link-FSM message request into a header word
// (plus optional payload word) for the 64b serializer, or sends the init start pattern.
module sb_tx_packet_framer #(
  parameter int          PATTERN_WORDS = 4,
  parameter int          GAP_CYCLES    = 2,
  parameter logic [63:0] PATTERN_WORD  = 64'hAAAA_AAAA_AAAA_AAAA
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_pattern,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_has_data,
  input  logic [7:0]  i_msg_code,
  input  logic [7:0]  i_msg_sub_code,
  input  logic [15:0] i_msg_info,
  input  logic [63:0] i_data,
  output logic        o_ser_valid,
  output logic [63:0] o_ser_data,
  input  logic        i_ser_ack,
  output logic        o_pattern_done,
  output logic        o_pkt_sent,
  output logic        o_busy
);

  localparam int PCW = $clog2(PATTERN_WORDS) + 1;
  localparam int GCW = $clog2(GAP_CYCLES) + 1;
  localparam logic [PCW-1:0] PAT_LAST = PCW'(PATTERN_WORDS - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PATTERN, HEADER, DATA, GAP} state_t;

  state_t          state_q;
  logic            ser_valid_q;
  logic [63:0]     ser_data_q;
  logic            pattern_done_q;
  logic            pkt_sent_q;
  logic            has_data_q;
  logic [63:0]     data_q;
  logic [PCW-1:0]  pat_cnt_q;
  logic [GCW-1:0]  gap_cnt_q;
  logic            accept;

  // cp covers bits [61:0]; dp is payload parity and only meaningful with a payload
  function automatic logic [63:0] build_hdr(input logic        has_data,
                                            input logic [7:0]  code,
                                            input logic [7:0]  sub_code,
                                            input logic [15:0] info,
                                            input logic [63:0] data);
    logic [63:0] h;
    h        = '0;
    h[4:0]   = has_data ? 5'b11011 : 5'b10010;
    h[21:14] = code;
    h[31:29] = 3'b001;
    h[39:32] = sub_code;
    h[55:40] = info;
    h[58:56] = 3'b101;
    h[62]    = ^h[61:0];
    h[63]    = has_data & (^data);
    return h;
  endfunction

  assign o_req_ready    = (state_q == IDLE) & ~i_start_pattern & ~i_rst;
  assign accept         = i_req_valid & o_req_ready;
  assign o_ser_valid    = ser_valid_q;
  assign o_ser_data     = ser_data_q;
  assign o_pattern_done = pattern_done_q;
  assign o_pkt_sent     = pkt_sent_q;
  assign o_busy         = (state_q != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      ser_valid_q    <= 1'b0;
      ser_data_q     <= '0;
      pattern_done_q <= 1'b0;
      pkt_sent_q     <= 1'b0;
      has_data_q     <= 1'b0;
      data_q         <= '0;
      pat_cnt_q      <= '0;
      gap_cnt_q      <= '0;
    end else begin
      pattern_done_q <= 1'b0;
      pkt_sent_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start_pattern) begin
            state_q     <= PATTERN;
            pat_cnt_q   <= '0;
            ser_valid_q <= 1'b1;
            ser_data_q  <= PATTERN_WORD;
          end else if (accept) begin
            state_q     <= HEADER;
            has_data_q  <= i_has_data;
            data_q      <= i_has_data ? i_data : '0;
            ser_valid_q <= 1'b1;
            ser_data_q  <= build_hdr(i_has_data, i_msg_code, i_msg_sub_code,
                                     i_msg_info, i_data);
          end
        end
        PATTERN: begin
          if (i_ser_ack) begin
            if (pat_cnt_q == PAT_LAST) begin
              state_q        <= GAP;
              gap_cnt_q      <= '0;
              ser_valid_q    <= 1'b0;
              ser_data_q     <= '0;
              pattern_done_q <= 1'b1;
            end else begin
              pat_cnt_q <= pat_cnt_q + 1'b1;
            end
          end
        end
        HEADER: begin
          if (i_ser_ack) begin
            if (has_data_q) begin
              state_q    <= DATA;
              ser_data_q <= data_q;
            end else begin
              state_q     <= GAP;
              gap_cnt_q   <= '0;
              ser_valid_q <= 1'b0;
              ser_data_q  <= '0;
              pkt_sent_q  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (i_ser_ack) begin
            state_q     <= GAP;
            gap_cnt_q   <= '0;
            ser_valid_q <= 1'b0;
            ser_data_q  <= '0;
            pkt_sent_q  <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
